// File: rtl/bcd_timer_ssd.sv
// Multi-digit BCD up/down timer with start/pause FSM and a
// scanned seven-segment driver for the board display.
module bcd_timer_ssd #(
  parameter int          DIGITS    = 4,
  parameter logic [15:0] INIT_BCD  = 16'h0030,
  parameter int          SCAN_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic                start_pause,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                mode,
  output logic [4*DIGITS-1:0] count_bcd,
  output logic [7:0]          ssd,
  output logic [DIGITS-1:0]   ssd_en,
  output logic [14:0]         led,
  output logic                done
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE, RUN, PAUSE, DONE
  } state_t;

  state_t         state, n_state;
  logic [W-1:0]   count, term;
  logic           dir;
  logic [W-1:0]   n_count, n_term;
  logic           n_dir;
  logic [W-1:0]   ld_c, inc, dec;
  logic           cy, bw;

  logic [SCAN_BITS-1:0] pre;
  logic [1:0]           k;
  logic                 scan_on;
  logic [15:0]          cnt16;
  logic [3:0]           cur_dig;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 8'b00000011;
      4'd1:    return 8'b10011111;
      4'd2:    return 8'b00100101;
      4'd3:    return 8'b00001101;
      4'd4:    return 8'b10011001;
      4'd5:    return 8'b01001001;
      4'd6:    return 8'b01000001;
      4'd7:    return 8'b00011111;
      4'd8:    return 8'b00000001;
      4'd9:    return 8'b00001001;
      default: return 8'b11111111;
    endcase
  endfunction

  // Per-digit clamp plus ripple carry/borrow chains.
  always_comb begin
    ld_c = '0;
    inc  = count;
    dec  = count;
    cy   = 1'b1;
    bw   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      ld_c[4*i+:4] = (load_val[4*i+:4] > 4'd9) ?
                     4'd9 : load_val[4*i+:4];
      if (cy) begin
        if (count[4*i+:4] == 4'd9) begin
          inc[4*i+:4] = 4'd0;
        end else begin
          inc[4*i+:4] = count[4*i+:4] + 4'd1;
          cy = 1'b0;
        end
      end
      if (bw) begin
        if (count[4*i+:4] == 4'd0) begin
          dec[4*i+:4] = 4'd9;
        end else begin
          dec[4*i+:4] = count[4*i+:4] - 4'd1;
          bw = 1'b0;
        end
      end
    end
  end

  always_comb begin
    n_state = state;
    n_count = count;
    n_term  = term;
    n_dir   = dir;
    if (load) begin
      n_count = mode ? '0 : ld_c;
      n_term  = mode ? ld_c : '0;
      n_dir   = mode;
      n_state = IDLE;
    end else if (start_pause) begin
      unique case (state)
        IDLE:  n_state = (count == term) ? DONE : RUN;
        RUN:   n_state = PAUSE;
        PAUSE: n_state = RUN;
        DONE:  n_state = DONE;
      endcase
    end else if (tick && state == RUN) begin
      n_count = dir ? inc : dec;
      if (n_count == term) n_state = DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= INIT_BCD[W-1:0];
      term  <= '0;
      dir   <= 1'b0;
      led   <= '0;
    end else begin
      state <= n_state;
      count <= n_count;
      term  <= n_term;
      dir   <= n_dir;
      led   <= {15{n_state == DONE}};
    end
  end

  assign count_bcd = count;
  assign done      = (state == DONE);

  assign cnt16   = 16'(count);
  assign cur_dig = cnt16[{k, 2'b00} +: 4];

  // Display stays blank until the prescaler first wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre     <= '0;
      k       <= '0;
      scan_on <= 1'b0;
      ssd     <= 8'hFF;
      ssd_en  <= '1;
    end else begin
      pre <= pre + 1'b1;
      if (&pre) begin
        k       <= (k == 2'(DIGITS - 1)) ? 2'd0 : k + 2'd1;
        scan_on <= 1'b1;
      end
      ssd_en <= scan_on ? ~(DIGITS'(1) << k) : '1;
      ssd    <= scan_on ? seg7(cur_dig) : 8'hFF;
    end
  end

endmodule

// File: tb/tb_bcd_timer_ssd.sv
// Scoreboard bench for bcd_timer_ssd: decimal reference model,
// directed scenarios, random pulses and display scan checks.
module tb_bcd_timer_ssd;

  localparam logic [15:0] INIT = 16'h0030;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        start_pause = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_val = '0;
  logic        mode = 1'b0;
  logic [15:0] count_bcd;
  logic [7:0]  ssd;
  logic [3:0]  ssd_en;
  logic [14:0] led;
  logic        done;

  bcd_timer_ssd #(
    .DIGITS(4), .INIT_BCD(INIT), .SCAN_BITS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .start_pause(start_pause), .load(load),
    .load_val(load_val), .mode(mode),
    .count_bcd(count_bcd), .ssd(ssd), .ssd_en(ssd_en),
    .led(led), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] cnt;
    logic        dn;
  } exp_t;
  exp_t q[$];

  typedef enum {S_IDLE, S_RUN, S_PAUSE, S_DONE} ms_t;
  ms_t m_st;
  int  m_cnt, m_term;
  bit  m_up;

  logic [7:0] segtab [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF
  };

  function automatic logic [15:0] to_bcd(int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10),
            4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int clamp_val(logic [15:0] b);
    int r = 0;
    int w = 1;
    for (int i = 0; i < 4; i++) begin
      int d = int'((b >> (4 * i)) & 16'hF);
      r += (d > 9 ? 9 : d) * w;
      w *= 10;
    end
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_st = S_IDLE;
    m_cnt = 30;
    m_term = 0;
    m_up = 1'b0;
  endtask

  task automatic step(bit tk, bit sp, bit ld,
                      logic [15:0] lv, bit md);
    exp_t e;
    @(negedge clk);
    tick = tk;
    start_pause = sp;
    load = ld;
    load_val = lv;
    mode = md;
    if (ld) begin
      m_up = md;
      m_cnt = md ? 0 : clamp_val(lv);
      m_term = md ? clamp_val(lv) : 0;
      m_st = S_IDLE;
    end else if (sp) begin
      case (m_st)
        S_IDLE:  m_st = (m_cnt == m_term) ? S_DONE : S_RUN;
        S_RUN:   m_st = S_PAUSE;
        S_PAUSE: m_st = S_RUN;
        default: ;
      endcase
    end else if (tk && m_st == S_RUN) begin
      m_cnt = m_up ? m_cnt + 1 : m_cnt - 1;
      if (m_cnt == m_term) m_st = S_DONE;
    end
    e.cnt = to_bcd(m_cnt);
    e.dn = (m_st == S_DONE);
    q.push_back(e);
  endtask

  task automatic tk(int n = 1);
    for (int i = 0; i < n; i++) step(1, 0, 0, 16'h0, 0);
  endtask
  task automatic sp();
    step(0, 1, 0, 16'h0, 0);
  endtask
  task automatic ld(logic [15:0] v, bit m);
    step(0, 0, 1, v, m);
  endtask
  task automatic idle();
    step(0, 0, 0, 16'h0, 0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: pops expected count/done and checks the scan
  // output against the edge count since reset release.
  int          n = 0;
  logic [15:0] prev = INIT;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      q.delete();
      n = 0;
      prev = INIT;
    end else begin
      exp_t e;
      logic [15:0] cur;
      logic [3:0]  oh;
      logic [3:0]  en_x;
      logic [7:0]  seg_x;
      int          idx;
      n++;
      cur = prev;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("count", 32'(count_bcd), 32'(e.cnt));
        chk("done", 32'(done), 32'(e.dn));
        chk("led", 32'(led), e.dn ? 32'h7FFF : 32'h0);
        cur = e.cnt;
      end
      if (n - 1 >= 4) begin
        idx = ((n - 1) / 4) % 4;
        oh = 4'b0001 << idx;
        en_x = ~oh;
        seg_x = segtab[(prev >> (4 * idx)) & 16'hF];
      end else begin
        en_x = 4'hF;
        seg_x = 8'hFF;
      end
      chk("ssd_en", 32'(ssd_en), 32'(en_x));
      chk("ssd", 32'(ssd), 32'(seg_x));
      prev = cur;
    end
  end

  task automatic check_reset_vals(string tag);
    chk({tag, "_count"}, 32'(count_bcd), 32'(INIT));
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_led"}, 32'(led), 32'h0);
    chk({tag, "_ssd"}, 32'(ssd), 32'hFF);
    chk({tag, "_ssd_en"}, 32'(ssd_en), 32'hF);
  endtask

  initial begin
    model_reset();
    #12;
    check_reset_vals("rst0");
    @(negedge clk);
    rst_n = 1'b1;

    // Down from INIT to zero, then extra ticks hold.
    sp();
    tk(30);
    settle();
    chk("down_zero", 32'(count_bcd), 32'h0000);
    chk("down_done", 32'(done), 32'h1);
    tk(3);
    settle();
    chk("down_hold", 32'(count_bcd), 32'h0000);

    // Borrow across two digits.
    ld(16'h0109, 0);
    sp();
    tk(10);
    settle();
    chk("borrow", 32'(count_bcd), 32'h0099);

    // Up count to terminal with carry.
    ld(16'h0012, 1);
    sp();
    tk(12);
    settle();
    chk("up_term", 32'(count_bcd), 32'h0012);
    chk("up_done", 32'(led), 32'h7FFF);
    tk(2);

    // Pause has priority over a simultaneous tick.
    ld(16'h0050, 0);
    sp();
    tk(3);
    step(1, 1, 0, 16'h0, 0);
    tk(4);
    settle();
    chk("paused", 32'(count_bcd), 32'h0047);
    sp();
    tk(2);
    settle();
    chk("resumed", 32'(count_bcd), 32'h0045);

    // Digit clamp, then start at terminal.
    ld(16'h00A5, 0);
    settle();
    chk("clamp", 32'(count_bcd), 32'h0095);
    ld(16'h0000, 0);
    sp();
    settle();
    chk("start_at_term", 32'(done), 32'h1);
    idle();

    // Random pulses and loads.
    for (int i = 0; i < 2500; i++) begin
      bit t, s, l, m;
      logic [15:0] v;
      t = ($urandom_range(0, 99) < 60);
      s = ($urandom_range(0, 99) < 4);
      l = ($urandom_range(0, 99) < 2);
      m = 1'($urandom_range(0, 1));
      v = $urandom_range(0, 3) == 0 ?
          16'($urandom) : 16'($urandom_range(0, 99));
      step(t, s, l, v, m);
    end
    idle();

    // Asynchronous reset in the middle of a run.
    ld(16'h0020, 0);
    sp();
    tk(5);
    @(negedge clk);
    tick = 1'b0;
    start_pause = 1'b0;
    load = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sp();
    tk(6);
    idle();
    idle();
    settle();
    chk("after_rst", 32'(count_bcd), 32'h0024);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_timer_ssd.md
# bcd_timer_ssd

Parametrised multi-digit BCD timer with an integrated seven-segment scan driver. It is the next generation of the lab down-counter. It adds configurable digit count, runtime load, up or down counting, a start/pause state machine and a terminal flag. It sits between the debounced button/one-pulse logic and the board's SSD and LED pins, and is clocked by the system clock with externally generated tick pulses.

## Interface
- DIGITS, 4, number of BCD digits (2..4); digit 0 is least significant.
- INIT_BCD, 16'h0030, count value after reset, 4 bits per digit; only the low 4*DIGITS bits are used.
- SCAN_BITS, 16, width of the free-running scan prescaler.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- tick  input  1  single-cycle count-enable pulse.
- start_pause  input  1  single-cycle pulse that toggles run/pause.
- load  input  1  single-cycle pulse that loads load_val.
- load_val  input  4*DIGITS  BCD value for a load.
- mode  input  1  direction at load: 0 = down, 1 = up. Sampled only on load.
- count_bcd  output  4*DIGITS  current count, registered.
- ssd  output  8  segments {a,b,c,d,e,f,g,dp}, active-low, registered.
- ssd_en  output  DIGITS  digit enables, active-low one-hot, registered; bit 0 drives the rightmost digit.
- led  output  15  all ones while DONE, else zero, registered.
- done  output  1  high while state is DONE.

## Operation
- States are IDLE, RUN, PAUSE and DONE.
- Registers: count, term (terminal value), dir.
- Reset values: count = INIT_BCD, term = 0, dir = down, state = IDLE.
- Load (highest priority, any state):
  - Digits of load_val greater than 9 are clamped to 9.
  - Down: count ← clamped load_val, term ← 0, dir ← down.
  - Up: count ← 0, term ← clamped load_val, dir ← up.
  - Next state is IDLE.
- start_pause (if no load):
  - IDLE → RUN, or IDLE → DONE if count == term.
  - RUN → PAUSE.
  - PAUSE → RUN.
  - DONE: ignored.
- tick (only in RUN, and only if neither load nor start_pause is active that cycle):
  - Down: BCD decrement with borrow, so a digit at 0 becomes 9 and borrows from the next digit.
  - Up: BCD increment with carry, so a digit at 9 becomes 0 and carries.
  - If the result equals term, next state is DONE on the same edge.
- In DONE, count holds and ticks are ignored. Only load or reset leaves DONE.
- count never moves past term. Down never wraps below 0. Up never passes term, which is at most all-nines, so no wrap is possible.
- Display scan:
  - The SCAN_BITS prescaler free-runs from reset.
  - On each prescaler rollover, digit index k advances 0→1→…→DIGITS-1→0.
  - ssd_en = ~(1<<k); ssd = encoding of count digit k.
- Segment encoding:
  - 0 = 00000011
  - 1 = 10011111
  - 2 = 00100101
  - 3 = 00001101
  - 4 = 10011001
  - 5 = 01001001
  - 6 = 01000001
  - 7 = 00011111
  - 8 = 00000001
  - 9 = 00001001
  - Any other value = 11111111 (blank).

## Timing
- Every action takes effect at the clk edge where its pulse is sampled high.
- count_bcd, state, done and led are valid after that edge, with one-cycle latency.
- done and led rise on the edge that applies the terminal tick, in the same cycle count_bcd shows term.
- Reset values of outputs:
  - count_bcd = INIT_BCD, done = 0, led = 0.
  - ssd = 8'hFF and ssd_en = all ones (blank) until the first rollover; k = 0.
- ssd and ssd_en update one cycle after the index changes. ssd also tracks count changes with one cycle of latency.
- Pulses held high for several cycles act on every cycle. Debouncing and one-pulse conversion are done upstream.
- Reset asserted mid-count immediately forces the reset values. There are no partial updates.

## Test plan
- Reset with INIT_BCD=0030, then start_pause and 30 ticks.
  - count_bcd goes 0030→0029→…→0000.
  - done and led become 1 on the 30th tick.
  - Further ticks leave 0000.
- Load 0x0109 with mode=0, start, 10 ticks → 0099 after the 10th tick.
  - This checks the borrow across two digits.
- Load 0x0012 with mode=1, start, ticks → 0000, 0001 … 0009, 0010, 0011, 0012.
  - DONE asserts at 0012.
  - This checks the carry and the up terminal.
- In RUN, pulse start_pause and tick in the same cycle → state PAUSE, count unchanged.
  - Ticks while paused are ignored.
  - A second start_pause resumes.
- load_val 0x00A5, mode=0 → count_bcd = 0095.
  - start_pause with count == term = 0 goes straight to DONE.
- Scan check with SCAN_BITS=2 and DIGITS=4.
  - ssd_en cycles 1110, 1101, 1011, 0111 every 4 clocks.
  - ssd matches each digit's encoding.
  - Assert rst_n mid-run → all outputs return to their reset values asynchronously.
